// File: rtl/brew_sequencer.sv
// Brew sequencer: turns the sensor FSM status code into heater/pump control,
// produces the error timeout back to the sensor FSM and latches faults for the panel.
module brew_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned HEAT_CYC    = 8,
    parameter int unsigned PUMP_SHORT  = 10,
    parameter int unsigned PUMP_LONG   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       size,
    input  logic       clear,
    input  logic [2:0] status,
    output logic       timer,
    output logic       heater,
    output logic       pump,
    output logic       ready,
    output logic       done,
    output logic       alarm,
    output logic [2:0] err_code
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_FIX,
        HEAT,
        BREW,
        DONE_ST,
        FAULT
    } state_t;

    localparam logic [2:0] CODE_ANALYSE = 3'b000;
    localparam logic [2:0] CODE_SENSOR  = 3'b100;
    localparam logic [2:0] CODE_OK      = 3'b101;
    localparam logic [2:0] CODE_NONE    = 3'b000;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [7:0] TIMEOUT_SAT  = 8'(TIMEOUT_CYC);
    localparam logic [7:0] HEAT_LAST    = 8'(HEAT_CYC - 1);
    localparam logic [7:0] SHORT_LAST   = 8'(PUMP_SHORT - 1);
    localparam logic [7:0] LONG_LAST    = 8'(PUMP_LONG - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       size_q, size_next;
    logic [2:0] err_next;
    logic       status_err;
    logic [7:0] brew_last;

    assign status_err = (status == 3'b001) || (status == 3'b010) || (status == 3'b011);
    assign brew_last  = size_q ? LONG_LAST : SHORT_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            size_q   <= 1'b0;
            err_code <= CODE_NONE;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            size_q   <= size_next;
            err_code <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        size_next  = size_q;
        err_next   = err_code;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CHECK;
                    size_next  = size;
                    cnt_next   = 8'd0;
                end
            end
            CHECK: begin
                if (status == CODE_OK) begin
                    state_next = HEAT;
                    cnt_next   = 8'd0;
                end else if (status_err) begin
                    state_next = WAIT_FIX;
                    err_next   = status;
                    cnt_next   = 8'd0;
                end else if (status == CODE_ANALYSE) begin
                    // A sensor FSM stuck analysing is treated as a sensor fault.
                    if (cnt == TIMEOUT_LAST) begin
                        state_next = FAULT;
                        err_next   = CODE_SENSOR;
                    end else begin
                        cnt_next = cnt + 8'd1;
                    end
                end else begin
                    state_next = FAULT;
                    err_next   = CODE_SENSOR;
                end
            end
            WAIT_FIX: begin
                if (status == CODE_OK) begin
                    state_next = HEAT;
                    err_next   = CODE_NONE;
                    cnt_next   = 8'd0;
                end else if (status_err && (status != err_code)) begin
                    // A new error class restarts the timeout window from zero.
                    err_next = status;
                    cnt_next = 8'd0;
                end else if (status_err || (status == CODE_ANALYSE)) begin
                    if (cnt != TIMEOUT_SAT) begin
                        cnt_next = cnt + 8'd1;
                    end
                end else begin
                    state_next = FAULT;
                    err_next   = CODE_SENSOR;
                end
            end
            HEAT: begin
                if (cnt == HEAT_LAST) begin
                    state_next = BREW;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            BREW: begin
                if (cnt == brew_last) begin
                    state_next = DONE_ST;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DONE_ST: begin
                state_next = IDLE;
            end
            FAULT: begin
                err_next = CODE_SENSOR;
                if (clear) begin
                    state_next = IDLE;
                    err_next   = CODE_NONE;
                    cnt_next   = 8'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
                err_next   = CODE_NONE;
            end
        endcase
    end

    // Outputs decode state only, so reset drops the actuators immediately.
    always_comb begin
        timer  = 1'b0;
        heater = 1'b0;
        pump   = 1'b0;
        ready  = 1'b0;
        done   = 1'b0;
        alarm  = 1'b0;
        case (state)
            IDLE:     ready  = 1'b1;
            WAIT_FIX: timer  = (cnt == TIMEOUT_SAT);
            HEAT:     heater = 1'b1;
            BREW: begin
                heater = 1'b1;
                pump   = 1'b1;
            end
            DONE_ST:  done   = 1'b1;
            FAULT:    alarm  = 1'b1;
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// Self-checking bench for brew_sequencer: directed scenarios plus random traffic,
// compared every cycle against a phase/countdown model of the brewing rules.
module tb_brew_sequencer;

    localparam int TO = 16;
    localparam int HC = 8;
    localparam int PS = 10;
    localparam int PL = 20;

    localparam int P_IDLE  = 0;
    localparam int P_CHECK = 1;
    localparam int P_WAIT  = 2;
    localparam int P_HEAT  = 3;
    localparam int P_BREW  = 4;
    localparam int P_DONE  = 5;
    localparam int P_FAULT = 6;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic       size   = 1'b0;
    logic       clear  = 1'b0;
    logic [2:0] status = 3'b000;
    logic       timer, heater, pump, ready, done, alarm;
    logic [2:0] err_code;

    int tests  = 0;
    int failed = 0;

    int         m_phase;
    int         m_age;
    int         m_left;
    bit         m_long;
    logic [2:0] m_err;

    int done_seen;
    int pump_seen;
    int timer_seen;

    brew_sequencer #(
        .TIMEOUT_CYC(TO),
        .HEAT_CYC   (HC),
        .PUMP_SHORT (PS),
        .PUMP_LONG  (PL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .size    (size),
        .clear   (clear),
        .status  (status),
        .timer   (timer),
        .heater  (heater),
        .pump    (pump),
        .ready   (ready),
        .done    (done),
        .alarm   (alarm),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        m_phase = P_IDLE;
        m_age   = 0;
        m_left  = 0;
        m_long  = 1'b0;
        m_err   = 3'b000;
    endtask

    task automatic goFault();
        m_phase = P_FAULT;
        m_err   = 3'b100;
    endtask

    // One clock edge of the brewing rules, using countdowns and error age.
    task automatic modelStep();
        int s;
        s = int'(status);
        case (m_phase)
            P_IDLE: if (start) begin
                m_phase = P_CHECK;
                m_long  = size;
                m_age   = 0;
            end
            P_CHECK: begin
                if (s == 5) begin
                    m_phase = P_HEAT;
                    m_left  = HC;
                end else if (s >= 1 && s <= 3) begin
                    m_phase = P_WAIT;
                    m_err   = status;
                    m_age   = 0;
                end else if (s == 0) begin
                    if (m_age == TO - 1) goFault();
                    else m_age++;
                end else goFault();
            end
            P_WAIT: begin
                if (s == 5) begin
                    m_phase = P_HEAT;
                    m_left  = HC;
                    m_err   = 3'b000;
                end else if (s == 4 || s >= 6) goFault();
                else if (s != 0 && status != m_err) begin
                    m_err = status;
                    m_age = 0;
                end else m_age++;
            end
            P_HEAT: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_BREW;
                    m_left  = m_long ? PL : PS;
                end
            end
            P_BREW: begin
                m_left--;
                if (m_left == 0) m_phase = P_DONE;
            end
            P_DONE: m_phase = P_IDLE;
            default: if (clear) begin
                m_phase = P_IDLE;
                m_err   = 3'b000;
            end
        endcase
    endtask

    task automatic expectVal(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        expectVal({tag, ".timer"},  int'(timer),    int'(m_phase == P_WAIT && m_age >= TO));
        expectVal({tag, ".heater"}, int'(heater),   int'(m_phase == P_HEAT || m_phase == P_BREW));
        expectVal({tag, ".pump"},   int'(pump),     int'(m_phase == P_BREW));
        expectVal({tag, ".ready"},  int'(ready),    int'(m_phase == P_IDLE));
        expectVal({tag, ".done"},   int'(done),     int'(m_phase == P_DONE));
        expectVal({tag, ".alarm"},  int'(alarm),    int'(m_phase == P_FAULT));
        expectVal({tag, ".err"},    int'(err_code), int'(m_err));
        if (done === 1'b1)  done_seen++;
        if (pump === 1'b1)  pump_seen++;
        if (timer === 1'b1) timer_seen++;
    endtask

    // Drive inputs at the falling edge, step the model on the rising edge, check at the next falling edge.
    task automatic applyStimulus(string tag, logic st, logic sz, logic cl, logic [2:0] stat);
        start  = st;
        size   = sz;
        clear  = cl;
        status = stat;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic clearCounts();
        done_seen  = 0;
        pump_seen  = 0;
        timer_seen = 0;
    endtask

    initial begin
        logic [2:0] rstat;
        modelReset();
        clearCounts();
        #12;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        clearCounts();
        applyStimulus("short_start", 1'b1, 1'b0, 1'b0, 3'b101);
        for (int i = 0; i < 21; i++) applyStimulus("short", 1'b0, 1'b0, 1'b0, 3'b101);
        expectVal("short_pump_cycles", pump_seen, PS);
        expectVal("short_done_pulses", done_seen, 1);

        clearCounts();
        applyStimulus("long_start", 1'b1, 1'b1, 1'b0, 3'b101);
        for (int i = 0; i < 31; i++) applyStimulus("long", 1'b0, 1'b0, 1'b0, 3'b101);
        expectVal("long_pump_cycles", pump_seen, PL);

        clearCounts();
        applyStimulus("water_start", 1'b1, 1'b0, 1'b0, 3'b001);
        for (int i = 0; i < 6; i++) applyStimulus("water_wait", 1'b0, 1'b0, 1'b0, 3'b001);
        for (int i = 0; i < 22; i++) applyStimulus("water_fixed", 1'b0, 1'b0, 1'b0, 3'b101);
        expectVal("water_timer_cycles", timer_seen, 0);
        expectVal("water_done_pulses", done_seen, 1);

        clearCounts();
        applyStimulus("timeout_start", 1'b1, 1'b0, 1'b0, 3'b010);
        for (int i = 0; i < 25; i++) applyStimulus("timeout_hold", 1'b0, 1'b0, 1'b0, 3'b010);
        expectVal("timeout_timer_cycles", timer_seen, 26 - 1 - TO);
        applyStimulus("timeout_fault", 1'b0, 1'b0, 1'b0, 3'b100);
        applyStimulus("fault_hold", 1'b1, 1'b0, 1'b0, 3'b100);
        applyStimulus("start_clear", 1'b1, 1'b0, 1'b1, 3'b100);
        applyStimulus("after_clear", 1'b0, 1'b0, 1'b0, 3'b101);

        clearCounts();
        applyStimulus("class_start", 1'b1, 1'b0, 1'b0, 3'b001);
        for (int i = 0; i < 10; i++) applyStimulus("class_water", 1'b0, 1'b0, 1'b0, 3'b001);
        for (int i = 0; i < 20; i++) applyStimulus("class_cup", 1'b0, 1'b0, 1'b0, 3'b011);
        expectVal("class_timer_cycles", timer_seen, 20 - TO);
        applyStimulus("class_fault", 1'b0, 1'b0, 1'b0, 3'b110);
        applyStimulus("class_clear", 1'b0, 1'b0, 1'b1, 3'b000);

        applyStimulus("rst_start", 1'b1, 1'b1, 1'b0, 3'b101);
        for (int i = 0; i < 1 + HC + 3; i++) applyStimulus("rst_run", 1'b0, 1'b0, 1'b0, 3'b101);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("rst_fresh", 1'b1, 1'b0, 1'b0, 3'b000);
        applyStimulus("rst_check", 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 22; i++) applyStimulus("rst_brew", 1'b0, 1'b0, 1'b0, 3'b101);

        clearCounts();
        applyStimulus("heat_start", 1'b1, 1'b0, 1'b0, 3'b101);
        applyStimulus("heat_enter", 1'b0, 1'b0, 1'b0, 3'b101);
        for (int i = 0; i < HC; i++) applyStimulus("heat_restart", 1'b1, 1'b0, 1'b0, 3'b101);
        for (int i = 0; i < 20; i++) applyStimulus("heat_finish", 1'b0, 1'b0, 1'b0, 3'b101);
        expectVal("heat_done_pulses", done_seen, 1);

        applyStimulus("illegal_start", 1'b1, 1'b0, 1'b0, 3'b111);
        applyStimulus("illegal_fault", 1'b0, 1'b0, 1'b0, 3'b111);
        applyStimulus("illegal_clear", 1'b0, 1'b0, 1'b1, 3'b111);

        rstat = 3'b101;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rstat = ($urandom_range(0, 2) == 0) ? 3'b101 : 3'($urandom_range(0, 7));
            end
            applyStimulus("random", 1'($urandom_range(0, 3) == 0), 1'($urandom),
                          1'($urandom_range(0, 5) == 0), rstat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
